// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: the pattern table used by both the
// display driver and this read-back path, a decoder and a one-hot helper.
package seg_pkg;

    // Segment bit order is {A,B,C,D,E,F,G} = seg[6:0]; index equals hex value.
    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    // Frame state machine encoding.
    localparam logic [0:0] FRAME_COLLECT = 1'b0;
    localparam logic [0:0] FRAME_PUBLISH = 1'b1;

    // Result of decoding one digit pattern.
    typedef struct packed {
        logic       err;
        logic [3:0] value;
    } seg_decode_t;

    // Reverse lookup of a segment pattern; unknown patterns give value 0, err 1.
    function automatic seg_decode_t seg_decode(input logic [6:0] pattern);
        seg_decode_t result;
        result.err   = 1'b1;
        result.value = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_PATTERNS[i]) begin
                result.err   = 1'b0;
                result.value = 4'(i);
            end
        end
        return result;
    endfunction

    // True when exactly one bit is set (callers zero-extend narrower selects).
    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/seg_stable_detect.sv
// Synchronizes the display bus and flags a digit pattern once it has been
// held steady long enough; the strobe fires once per stable window.
module seg_stable_detect
    import seg_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIGITS-1:0] an,
    input  logic [6:0]        seg,
    output logic [DIGITS-1:0] an_sync,
    output logic [6:0]        seg_sync,
    output logic              capture
);

    localparam int         W       = DIGITS + 7;
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_ARM = 8'(STABLE_CYCLES - 2);

    logic [W-1:0] meta;
    logic [W-1:0] sync;
    logic [W-1:0] prev;
    logic [7:0]   cnt;
    logic         stable;

    // Two-flop synchronizer plus a copy of the previous synchronized sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
        end else begin
            meta <= {an, seg};
            sync <= meta;
            prev <= sync;
        end
    end

    // A sample only counts toward stability if it repeats and selects one digit.
    always_comb begin
        stable = (sync == prev) && is_onehot(8'(sync[W-1:7]));
    end

    // Saturating stability counter, cleared by any change or invalid select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (!stable) begin
            cnt <= 8'd0;
        end else if (cnt < CNT_MAX) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign capture  = stable && (cnt == CNT_ARM);
    assign an_sync  = sync[W-1:7];
    assign seg_sync = sync[6:0];

endmodule

// File: rtl/segment_reader.sv
// Reads a multiplexed seven-segment bus back into hex digits and publishes
// a complete frame once every digit position has been captured.
module segment_reader
    import seg_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     an,
    input  logic [6:0]            seg,
    output logic                  capture,
    output logic                  frame_valid,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     digit_err
);

    logic [DIGITS-1:0]   an_sync;
    logic [6:0]          seg_sync;
    logic                cap_strobe;
    seg_decode_t         dec;
    logic [3:0]          shadow_val [DIGITS];
    logic [DIGITS-1:0]   shadow_err;
    logic [4*DIGITS-1:0] shadow_flat;
    logic [DIGITS-1:0]   seen;
    logic [0:0]          state;
    logic                publish_now;

    seg_stable_detect #(
        .DIGITS        (DIGITS),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_detect (
        .clk      (clk),
        .rst_n    (rst_n),
        .an       (an),
        .seg      (seg),
        .an_sync  (an_sync),
        .seg_sync (seg_sync),
        .capture  (cap_strobe)
    );

    assign dec = seg_decode(seg_sync);

    // Publish as soon as all digits are seen; PUBLISH blocks an immediate repeat.
    always_comb begin
        publish_now = (state == FRAME_COLLECT) && (&seen);
    end

    // Flatten the shadow slots into the output frame layout.
    always_comb begin
        shadow_flat = '0;
        for (int i = 0; i < DIGITS; i++) begin
            shadow_flat[4*i +: 4] = shadow_val[i];
        end
    end

    // Shadow slots hold the most recent capture of each digit position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                shadow_val[i] <= 4'h0;
            end
            shadow_err <= '0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (cap_strobe && an_sync[i]) begin
                    shadow_val[i] <= dec.value;
                    shadow_err[i] <= dec.err;
                end
            end
        end
    end

    // Seen mask: cleared on publish, with a same-cycle capture landing after the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen <= '0;
        end else begin
            seen <= (publish_now ? '0 : seen) | (cap_strobe ? an_sync : '0);
        end
    end

    // Frame state machine: PUBLISH marks the single cycle frame_valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FRAME_COLLECT;
        end else begin
            case (state)
                FRAME_COLLECT: if (publish_now) state <= FRAME_PUBLISH;
                FRAME_PUBLISH: state <= FRAME_COLLECT;
                default:       state <= FRAME_COLLECT;
            endcase
        end
    end

    // Registered outputs: capture pulse, frame pulse and the published frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            capture     <= 1'b0;
            frame_valid <= 1'b0;
            digits      <= '0;
            digit_err   <= '0;
        end else begin
            capture     <= cap_strobe;
            frame_valid <= publish_now;
            if (publish_now) begin
                digits    <= shadow_flat;
                digit_err <= shadow_err;
            end
        end
    end

endmodule

// File: tb/tb_segment_reader.sv
// Self-checking bench for segment_reader: directed scans plus random bus
// traffic, compared every cycle against a run-length based reference model.
module tb_segment_reader;

    localparam int DIGITS = 4;
    localparam int STABLE = 4;
    localparam int HIST   = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [DIGITS-1:0]     an = '0;
    logic [6:0]            seg = '0;
    logic                  capture;
    logic                  frame_valid;
    logic [4*DIGITS-1:0]   digits;
    logic [DIGITS-1:0]     digit_err;

    int vectors = 0;
    int miscompares = 0;
    int cycle_cnt = 0;
    int change_cycle = 0;
    int cap_count = 0;
    int fv_count = 0;
    int last_cap_cycle = -1;
    logic monitor_en = 1'b0;

    // Reference model state.
    logic [DIGITS+6:0]   hist [HIST];
    logic [3:0]          m_val [DIGITS];
    logic [DIGITS-1:0]   m_err;
    logic [DIGITS-1:0]   m_seen;
    logic                exp_cap;
    logic                exp_fv;
    logic [4*DIGITS-1:0] exp_digits;
    logic [DIGITS-1:0]   exp_err;

    segment_reader #(
        .DIGITS        (DIGITS),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .seg         (seg),
        .capture     (capture),
        .frame_valid (frame_valid),
        .digits      (digits),
        .digit_err   (digit_err)
    );

    always #5 clk = ~clk;

    // Independent copy of the segment table: {err, value}.
    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        case (p)
            7'h7E: return 5'h00;  7'h30: return 5'h01;
            7'h6D: return 5'h02;  7'h79: return 5'h03;
            7'h33: return 5'h04;  7'h5B: return 5'h05;
            7'h5F: return 5'h06;  7'h70: return 5'h07;
            7'h7F: return 5'h08;  7'h7B: return 5'h09;
            7'h77: return 5'h0A;  7'h1F: return 5'h0B;
            7'h4E: return 5'h0C;  7'h3D: return 5'h0D;
            7'h4F: return 5'h0E;  7'h47: return 5'h0F;
            default: return 5'h10;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, actual, expected, cycle_cnt);
        end
    endtask

    // A capture is due when the bus value two samples back ends a run of
    // exactly STABLE identical one-hot samples.
    task automatic modelStep();
        logic       cap;
        logic       pub;
        logic [4:0] d;
        if (!rst_n) begin
            for (int k = 0; k < HIST; k++) hist[k] = '0;
            for (int i = 0; i < DIGITS; i++) m_val[i] = 4'h0;
            m_err = '0; m_seen = '0;
            exp_cap = 1'b0; exp_fv = 1'b0; exp_digits = '0; exp_err = '0;
        end else begin
            for (int k = HIST - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = {an, seg};
            cap = ($countones(hist[2][DIGITS+6:7]) == 1);
            for (int k = 3; k <= STABLE + 1; k++) begin
                if (hist[k] != hist[2]) cap = 1'b0;
            end
            if (hist[STABLE+2] == hist[2]) cap = 1'b0;
            pub = &m_seen;
            if (pub) begin
                for (int i = 0; i < DIGITS; i++) exp_digits[4*i +: 4] = m_val[i];
                exp_err = m_err;
                m_seen = '0;
            end
            exp_fv = pub;
            exp_cap = cap;
            if (cap) begin
                d = ref_decode(hist[2][6:0]);
                for (int i = 0; i < DIGITS; i++) begin
                    if (hist[2][7+i]) begin
                        m_val[i] = d[3:0];
                        m_err[i] = d[4];
                        m_seen[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    // Per-cycle compare against the model, sampled 1 time unit after the edge.
    initial begin
        forever begin
            @(posedge clk);
            cycle_cnt++;
            modelStep();
            #1;
            if (monitor_en) begin
                checkOutput("capture", 32'(capture), 32'(exp_cap));
                checkOutput("frame_valid", 32'(frame_valid), 32'(exp_fv));
                checkOutput("digits", 32'(digits), 32'(exp_digits));
                checkOutput("digit_err", 32'(digit_err), 32'(exp_err));
                if (capture === 1'b1) begin
                    cap_count++;
                    last_cap_cycle = cycle_cnt;
                end
                if (frame_valid === 1'b1) fv_count++;
            end
        end
    end

    task automatic applyStimulus(input logic [DIGITS-1:0] a, input logic [6:0] s,
                                 input int cycles);
        @(negedge clk);
        an = a;
        seg = s;
        change_cycle = cycle_cnt;
        repeat (cycles) @(posedge clk);
    endtask

    task automatic runScan(input logic [27:0] pats, input logic [3:0] mask,
                           input int hold, input int gap);
        for (int i = 0; i < DIGITS; i++) begin
            if (mask[i]) begin
                applyStimulus(DIGITS'(1 << i), pats[7*i +: 7], hold);
                if (gap > 0) applyStimulus('0, 7'h00, gap);
            end
        end
        applyStimulus('0, 7'h00, 4);
    endtask

    initial begin
        logic [DIGITS-1:0] ra;
        logic [6:0]        rs;
        for (int k = 0; k < HIST; k++) hist[k] = '0;

        // Reset with a pattern already on the bus: everything stays zero.
        #1 rst_n = 1'b0;
        an = 4'b0001; seg = 7'h7E;
        monitor_en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_digits", 32'(digits), 32'h0);
        checkOutput("reset_capture", 32'(capture), 32'h0);
        @(negedge clk);
        an = '0; seg = 7'h00; rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single digit held 10 cycles: one capture, 6 edges after the change.
        cap_count = 0; fv_count = 0;
        applyStimulus(4'b0001, 7'h7E, 10);
        checkOutput("t1_cap_count", 32'(cap_count), 32'd1);
        checkOutput("t1_latency", 32'(last_cap_cycle - change_cycle), 32'd6);
        checkOutput("t1_fv_count", 32'(fv_count), 32'd0);

        // Clean scan of all four digits.
        fv_count = 0;
        runScan({7'h3D, 7'h77, 7'h5F, 7'h79}, 4'b1111, 8, 2);
        checkOutput("t2_fv_count", 32'(fv_count), 32'd1);
        checkOutput("t2_digits", 32'(digits), 32'hDA63);
        checkOutput("t2_err", 32'(digit_err), 32'h0);

        // Digit 2 carries an undecodable pattern.
        fv_count = 0;
        runScan({7'h3D, 7'h01, 7'h5F, 7'h79}, 4'b1111, 8, 2);
        checkOutput("t3_fv_count", 32'(fv_count), 32'd1);
        checkOutput("t3_digits", 32'(digits), 32'hD063);
        checkOutput("t3_err", 32'(digit_err), 32'h4);

        // Glitchy scan: holds too short to ever stabilise.
        cap_count = 0; fv_count = 0;
        runScan({7'h30, 7'h30, 7'h30, 7'h30}, 4'b1111, 3, 2);
        checkOutput("t4_cap_count", 32'(cap_count), 32'd0);
        checkOutput("t4_fv_count", 32'(fv_count), 32'd0);
        checkOutput("t4_digits", 32'(digits), 32'hD063);

        // Two digits selected at once is ignored, then a normal scan works.
        cap_count = 0;
        applyStimulus(4'b0011, 7'h7E, 20);
        applyStimulus('0, 7'h00, 4);
        checkOutput("t5_cap_count", 32'(cap_count), 32'd0);
        fv_count = 0;
        runScan({7'h3D, 7'h77, 7'h5F, 7'h79}, 4'b1111, 8, 2);
        checkOutput("t5_fv_count", 32'(fv_count), 32'd1);
        checkOutput("t5_digits", 32'(digits), 32'hDA63);

        // Reset after three captures discards the partial frame.
        runScan({7'h30, 7'h30, 7'h30, 7'h30}, 4'b0111, 8, 2);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("t6_reset_digits", 32'(digits), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        fv_count = 0;
        runScan({7'h4F, 7'h00, 7'h00, 7'h00}, 4'b1000, 8, 2);
        checkOutput("t6_partial_fv", 32'(fv_count), 32'd0);
        runScan({7'h00, 7'h7F, 7'h5B, 7'h47}, 4'b0111, 8, 2);
        checkOutput("t6_fv_count", 32'(fv_count), 32'd1);
        checkOutput("t6_digits", 32'(digits), 32'hE85F);

        // Random bus traffic checked by the per-cycle model compare.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) ra = DIGITS'($urandom_range(0, 15));
            else ra = DIGITS'(1 << $urandom_range(0, DIGITS - 1));
            if ($urandom_range(0, 7) == 0) rs = 7'($urandom_range(0, 127));
            else rs = ref_table(4'($urandom_range(0, 15)));
            applyStimulus(ra, rs, $urandom_range(1, 9));
            if ($urandom_range(0, 1) == 1) applyStimulus('0, 7'h00, $urandom_range(1, 3));
        end
        applyStimulus('0, 7'h00, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Forward table used only to pick legal random patterns.
    function automatic logic [6:0] ref_table(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        return t[v];
    endfunction

endmodule
